// File: rtl/coin_pkg.sv
// Shared types for the coin conditioner: FSM state, coin-type encoding and
// the counter width helper used by the debounce and lockout counters.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        NICKEL  = 2'd1,
        DIME    = 2'd2,
        QUARTER = 2'd3
    } coin_t;

    // Bits needed to hold a counter for the given parameter value, never 0.
    function automatic int cnt_width(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One sensor channel: 2-flop synchronizer, debounce counter and a one-cycle
// rise pulse when the debounced level goes from 0 to 1.
module debounce_ch
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta;
    logic          sync_x;
    logic [CW-1:0] cnt;

    // Bring the asynchronous sensor into the clock domain.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync_x    <= 1'b0;
        end else begin
            sync_meta <= raw;
            sync_x    <= sync_meta;
        end
    end

    // Count consecutive disagreeing samples; flip the level on the last one.
    // The rise pulse is registered alongside the flip so it lasts one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (sync_x == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_x;
                rise  <= sync_x;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/coin_conditioner.sv
// Coin conditioner: debounces three coin sensors and turns accepted coin
// arrivals into one-cycle N/D/Q pulses, with a lockout window and a wait for
// all sensors to clear before the next coin. Simultaneous or late arrivals
// produce a one-cycle reject pulse instead. The FSM state is exported for
// observation.
module coin_conditioner
    import coin_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   nickel_raw,
    input  logic   dime_raw,
    input  logic   quarter_raw,
    output logic   N,
    output logic   D,
    output logic   Q,
    output logic   reject,
    output logic   busy,
    output state_t state
);

    localparam int LW = cnt_width(LOCKOUT_CYCLES);
    localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

    // Bit 0 = nickel, bit 1 = dime, bit 2 = quarter.
    logic [2:0]    deb;
    logic [2:0]    rise;
    state_t        state_q;
    state_t        state_d;
    logic [LW-1:0] lock_q;
    logic [LW-1:0] lock_d;
    coin_t         coin_d;
    logic          reject_d;

    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
        .clk(clk), .reset(reset), .raw(nickel_raw), .level(deb[0]), .rise(rise[0])
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
        .clk(clk), .reset(reset), .raw(dime_raw), .level(deb[1]), .rise(rise[1])
    );
    debounce_ch #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_quarter (
        .clk(clk), .reset(reset), .raw(quarter_raw), .level(deb[2]), .rise(rise[2])
    );

    // State, lockout counter and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
            N       <= 1'b0;
            D       <= 1'b0;
            Q       <= 1'b0;
            reject  <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            N       <= (coin_d == NICKEL);
            D       <= (coin_d == DIME);
            Q       <= (coin_d == QUARTER);
            reject  <= reject_d;
        end
    end

    // Next state: any candidate edge in IDLE starts a lockout; the lockout
    // runs down to 0, then we hold until every debounced sensor reads 0.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        case (state_q)
            IDLE: begin
                if (|rise) begin
                    state_d = LOCKOUT;
                    lock_d  = LOCK_LOAD;
                end
            end
            LOCKOUT: begin
                if (lock_q == '0) begin
                    state_d = WAIT_RELEASE;
                end else begin
                    lock_d = lock_q - 1'b1;
                end
            end
            WAIT_RELEASE: begin
                if (deb == 3'b000) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                lock_d  = '0;
            end
        endcase
    end

    // Pulse selection: a lone edge in IDLE is a coin; several edges at once,
    // or any edge while busy, is a reject. Never both.
    always_comb begin
        coin_d   = NONE;
        reject_d = 1'b0;
        if (state_q == IDLE) begin
            case (rise)
                3'b000:  ;
                3'b001:  coin_d = NICKEL;
                3'b010:  coin_d = DIME;
                3'b100:  coin_d = QUARTER;
                default: reject_d = 1'b1;
            endcase
        end else begin
            reject_d = |rise;
        end
    end

    assign busy  = (state_q != IDLE);
    assign state = state_q;

endmodule

// File: tb/tb_coin_conditioner.sv
// Bench for coin_conditioner: a window-based reference model predicts every
// output pulse (cycle and kind) and the busy level; a monitor compares what
// the DUT shows against the expected queue. Directed scenarios also check
// absolute latencies, followed by randomized bouncy sensor traffic.
`timescale 1ns/1ps
module tb_coin_conditioner;

    localparam int DEB = 16;
    localparam int LOCK = 8;
    localparam int W = 35;
    localparam logic [2:0] K_N = 3'd1;
    localparam logic [2:0] K_D = 3'd2;
    localparam logic [2:0] K_Q = 3'd3;
    localparam logic [2:0] K_REJ = 3'd4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic nickel_raw = 1'b0;
    logic dime_raw = 1'b0;
    logic quarter_raw = 1'b0;
    logic N, D, Q, reject, busy;
    coin_pkg::state_t state;

    coin_conditioner #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
        .clk(clk), .reset(reset),
        .nickel_raw(nickel_raw), .dime_raw(dime_raw), .quarter_raw(quarter_raw),
        .N(N), .D(D), .Q(Q), .reject(reject), .busy(busy), .state(state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    logic [W-1:0] exp_q[$];
    logic exp_busy = 1'b0;
    int pulse_cnt = 0;
    int last_cyc = -1;
    logic [2:0] last_kind = 3'd0;

    task automatic check(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // hist[ch] bit k = raw value sampled k edges ago (0 while in reset).
    // The debounced level flips when the synchronized samples, which lag the
    // raw samples by two edges, have disagreed with it for DEB edges in a row.
    // A coin is accepted when it arrives alone while not engaged; the
    // engagement ends once LOCK cycles have elapsed and all levels are low.
    logic [DEB+3:0] hist[3];
    logic [2:0] m_deb = 3'b000;
    logic [2:0] m_rise = 3'b000;
    logic m_engaged = 1'b0;
    int m_accept = 0;

    always @(posedge clk) begin : model
        logic [2:0] raw_now;
        int k;
        logic flip;
        raw_now = {quarter_raw, dime_raw, nickel_raw};
        cyc++;
        if (reset) begin
            for (int ch = 0; ch < 3; ch++) hist[ch] = '0;
            m_deb = 3'b000;
            m_rise = 3'b000;
            m_engaged = 1'b0;
            exp_busy = 1'b0;
        end else begin
            k = int'(m_rise[0]) + int'(m_rise[1]) + int'(m_rise[2]);
            if (!m_engaged) begin
                if (k == 1) begin
                    if (m_rise[0]) exp_q.push_back({32'(cyc), K_N});
                    else if (m_rise[1]) exp_q.push_back({32'(cyc), K_D});
                    else exp_q.push_back({32'(cyc), K_Q});
                end else if (k > 1) begin
                    exp_q.push_back({32'(cyc), K_REJ});
                end
                if (k > 0) begin
                    m_engaged = 1'b1;
                    m_accept = cyc;
                end
            end else begin
                if (k > 0) exp_q.push_back({32'(cyc), K_REJ});
                else if ((cyc - m_accept > LOCK) && (m_deb == 3'b000)) m_engaged = 1'b0;
            end
            exp_busy = m_engaged;
            for (int ch = 0; ch < 3; ch++) begin
                hist[ch] = {hist[ch][DEB+2:0], raw_now[ch]};
                flip = (hist[ch][DEB+1:2] == {DEB{~m_deb[ch]}});
                m_rise[ch] = flip && !m_deb[ch];
                if (flip) m_deb[ch] = ~m_deb[ch];
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin : monitor
        int hi;
        logic [2:0] kind;
        logic [W-1:0] e;
        if (cyc > 0) begin
            while (exp_q.size() > 0 && int'(exp_q[0][W-1:3]) < cyc) begin
                e = exp_q.pop_front();
                check("missing_pulse_cycle", cyc, int'(e[W-1:3]));
            end
            hi = int'(N) + int'(D) + int'(Q) + int'(reject);
            check("pulse_exclusive", int'(hi > 1), 0);
            if (hi > 0) begin
                kind = N ? K_N : D ? K_D : Q ? K_Q : K_REJ;
                pulse_cnt++;
                last_cyc = cyc;
                last_kind = kind;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse_kind", int'(kind), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pulse_cycle", cyc, int'(e[W-1:3]));
                    check("pulse_kind", int'(kind), int'(e[2:0]));
                end
            end
            check("busy", int'(busy), int'(exp_busy));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_raw(input logic n, input logic d, input logic q);
        nickel_raw = n;
        dime_raw = d;
        quarter_raw = q;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic settle();
        set_raw(1'b0, 1'b0, 1'b0);
        tick(2 * (DEB + LOCK) + 8);
    endtask

    // ---------------- stimulus ----------------
    initial begin : stim
        int start;
        int p0;
        int hold[3];
        logic lvl[3];

        reset = 1'b1;
        tick(3);
        check("reset_N", int'(N), 0);
        check("reset_D", int'(D), 0);
        check("reset_Q", int'(Q), 0);
        check("reset_reject", int'(reject), 0);
        check("reset_busy", int'(busy), 0);
        reset = 1'b0;
        tick(2);

        // nickel held high: one N pulse 19 cycles later, busy afterwards
        p0 = pulse_cnt; start = cyc;
        set_raw(1'b1, 1'b0, 1'b0);
        tick(25);
        check("nickel_kind", int'(last_kind), int'(K_N));
        check("nickel_latency", last_cyc - start, DEB + 3);
        check("nickel_count", pulse_cnt - p0, 1);
        check("nickel_busy", int'(busy), 1);
        settle();
        do_reset();

        // dime bounces five times, then holds
        p0 = pulse_cnt;
        repeat (5) begin
            set_raw(1'b0, 1'b1, 1'b0); tick(3);
            set_raw(1'b0, 1'b0, 1'b0); tick(3);
        end
        start = cyc;
        set_raw(1'b0, 1'b1, 1'b0);
        tick(25);
        check("dime_kind", int'(last_kind), int'(K_D));
        check("dime_latency", last_cyc - start, DEB + 3);
        check("dime_count", pulse_cnt - p0, 1);
        settle();
        do_reset();

        // nickel and quarter together: reject only
        p0 = pulse_cnt; start = cyc;
        set_raw(1'b1, 1'b0, 1'b1);
        tick(25);
        check("double_kind", int'(last_kind), int'(K_REJ));
        check("double_latency", last_cyc - start, DEB + 3);
        check("double_count", pulse_cnt - p0, 1);
        settle();
        do_reset();

        // quarter, then dime two cycles later: Q, then reject two cycles after
        p0 = pulse_cnt; start = cyc;
        set_raw(1'b0, 1'b0, 1'b1);
        tick(2);
        set_raw(1'b0, 1'b1, 1'b1);
        tick(25);
        check("late_kind", int'(last_kind), int'(K_REJ));
        check("late_reject_cycle", last_cyc - start, DEB + 5);
        check("late_count", pulse_cnt - p0, 2);
        set_raw(1'b0, 1'b1, 1'b0);
        tick(40);
        check("late_busy_dime_held", int'(busy), 1);
        settle();
        check("late_busy_released", int'(busy), 0);
        do_reset();

        // reset in the middle of a nickel acceptance
        p0 = pulse_cnt; start = cyc;
        set_raw(1'b1, 1'b0, 1'b0);
        tick(10);
        do_reset();
        tick(25);
        check("reset_mid_kind", int'(last_kind), int'(K_N));
        check("reset_mid_latency", last_cyc - start, 30);
        check("reset_mid_count", pulse_cnt - p0, 1);
        settle();
        do_reset();

        // 10-cycle dime glitch: nothing happens
        p0 = pulse_cnt;
        set_raw(1'b0, 1'b1, 1'b0);
        tick(10);
        set_raw(1'b0, 1'b0, 1'b0);
        tick(30);
        check("glitch_count", pulse_cnt - p0, 0);
        check("glitch_busy", int'(busy), 0);

        // randomized bouncy traffic with occasional resets
        for (int ch = 0; ch < 3; ch++) begin
            hold[ch] = 0;
            lvl[ch] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < 3; ch++) begin
                if (hold[ch] == 0) begin
                    lvl[ch] = ($urandom_range(0, 2) == 0);
                    hold[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(DEB, DEB + 30)
                                                           : $urandom_range(1, DEB + 2);
                end else begin
                    hold[ch]--;
                end
            end
            reset = ($urandom_range(0, 499) == 0);
            set_raw(lvl[0], lvl[1], lvl[2]);
            tick(1);
        end
        reset = 1'b0;
        settle();
        check("queue_drained", exp_q.size(), 0);
        check("final_busy", int'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coin_conditioner.md
COIN_CONDITIONER -- requirements
Module: coin_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, consecutive stable synchronized samples needed to accept a level change (legal range 2..255).
REQ-002 Parameter LOCKOUT_CYCLES, default 8, cycles after an accepted coin during which no new coin is accepted (legal range 1..255).
REQ-003 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port nickel_raw, input, 1, asynchronous bouncing nickel sensor, high = coin present.
REQ-006 Port dime_raw, input, 1, asynchronous bouncing dime sensor, high = coin present.
REQ-007 Port quarter_raw, input, 1, asynchronous bouncing quarter sensor, high = coin present.
REQ-008 Port N, output, 1, one-cycle nickel pulse to the vending FSM.
REQ-009 Port D, output, 1, one-cycle dime pulse to the vending FSM.
REQ-010 Port Q, output, 1, one-cycle quarter pulse to the vending FSM.
REQ-011 Port reject, output, 1, one-cycle pulse: coin event discarded.
REQ-012 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-013 Each raw input SHALL pass through a 2-flop synchronizer; the sample is sync_x, 2 cycles after raw.
REQ-014 Each channel SHALL hold debounced level deb_x; it flips only after sync_x differs from deb_x for DEBOUNCE_CYCLES consecutive cycles; any matching sample clears the channel counter to 0.
REQ-015 A 0->1 flip of deb_x SHALL form a one-cycle candidate edge e_x; 1->0 flips produce no edge.
REQ-016 FSM states: IDLE, LOCKOUT, WAIT_RELEASE.
REQ-017 IDLE, exactly one e_x high: the matching output (N/D/Q) SHALL pulse high for exactly one cycle on the next cycle; FSM -> LOCKOUT, lockout counter loaded to LOCKOUT_CYCLES-1.
REQ-018 IDLE, two or three e_x high in the same cycle: reject pulses next cycle, no N/D/Q, FSM -> LOCKOUT.
REQ-019 LOCKOUT: counter decrements each cycle; at 0 FSM -> WAIT_RELEASE.
REQ-020 WAIT_RELEASE: when deb_nickel, deb_dime, deb_quarter are all 0, FSM -> IDLE next cycle.
REQ-021 Any e_x during LOCKOUT or WAIT_RELEASE SHALL be discarded and pulse reject next cycle; the state is unchanged and the counter is not reloaded.
REQ-022 At most one of N, D, Q SHALL be high in any cycle; reject and N/D/Q are never high together.
REQ-023 Latency: raw rising edge held stable -> coin pulse in exactly DEBOUNCE_CYCLES+3 cycles (19 at default).
REQ-024 Glitches shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no edge and no output.
REQ-025 N, D, Q, reject SHALL be registered outputs; busy is decoded from the state register.

Reset
REQ-026 reset high SHALL force state IDLE, all counters 0, deb_x 0, synchronizer flops 0, N=D=Q=reject=0, busy=0 on the next clock edge.
REQ-027 Reset asserted mid-pulse or mid-lockout SHALL abort immediately; no pulse is emitted afterwards for that event.
REQ-028 After reset release, an input already held high SHALL yield one coin pulse DEBOUNCE_CYCLES+3 cycles later.

Structure
REQ-029 Shared package coin_pkg SHALL hold the FSM state enum and the coin-type encoding (NONE, NICKEL, DIME, QUARTER).
REQ-030 Sub-module debounce_ch (synchronizer + debounce counter + edge detect, parameter DEBOUNCE_CYCLES) SHALL be instantiated three times.
REQ-031 Counter widths SHALL be clog2 of the parameter value, minimum 1.

Verification
REQ-032 nickel_raw held high from cycle 0 -> N=1 in cycle 19 only, busy high from cycle 19, reject never high.
REQ-033 dime_raw bounces 5 times (3-cycle pulses), then holds high -> exactly one D pulse, 19 cycles after the final rise.
REQ-034 nickel_raw and quarter_raw rise in the same cycle -> reject=1 in cycle 19, N=Q=0 throughout.
REQ-035 quarter accepted; dime rises 2 cycles later -> Q pulse, then reject pulse 2 cycles after Q, no D; IDLE only after both release.
REQ-036 reset asserted in cycle 10 of a 19-cycle nickel acceptance with nickel still high -> N stays 0 until cycle 30 (reset release at 11), then one N pulse.
REQ-037 10-cycle glitch on dime_raw -> no output, busy stays 0.
